// File: rtl/df_channel_monitor.sv
// df_channel_monitor
//   Watches NUM_CH ap_ctrl handshake channels and keeps per-channel start
//   count, done count and worst-case start-to-done latency. Once the bench
//   requests the end of the run and every channel has drained to IDLE,
//   mon_complete rises and all statistics freeze.
//
//   Optional feature: define DF_MON_STALL_DETECT_EN to build per-channel run
//   counters that raise a sticky stall flag after STALL_LIMIT consecutive
//   non-IDLE cycles. Without the macro, stall is tied low.
//
// Ports
//   clock                     single clock, rising edge
//   reset                     synchronous, active-high
//   finish                    end-of-run request (latched)
//   ap_start/ready/done/continue [NUM_CH]  per-channel handshake
//   rd_sel [4]                channel selected for readout
//   rd_start_cnt/rd_done_cnt/rd_max_lat [CNT_W]  registered stats of rd_sel
//   ch_busy [NUM_CH]          channel FSM not IDLE
//   stall [NUM_CH]            sticky stall flag
//   mon_complete              finish seen and all channels drained
//
// Channel FSM
//   state     | meaning
//   IDLE      | waiting for ap_start & ap_ready
//   BUSY      | transaction in flight, latency counting
//   WAIT_CONT | done already counted, waiting for ap_continue
module df_channel_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic [3:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_start_cnt,
    output logic [CNT_W-1:0]  rd_done_cnt,
    output logic [CNT_W-1:0]  rd_max_lat,
    output logic [NUM_CH-1:0] ch_busy,
    output logic [NUM_CH-1:0] stall,
    output logic              mon_complete
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        WAIT_CONT = 2'd2
    } ch_state_t;

    ch_state_t         state      [NUM_CH];
    ch_state_t         state_next [NUM_CH];
    logic [CNT_W-1:0]  start_cnt  [NUM_CH];
    logic [CNT_W-1:0]  done_cnt   [NUM_CH];
    logic [CNT_W-1:0]  max_lat    [NUM_CH];
    logic [CNT_W-1:0]  lat_cur    [NUM_CH];
    logic [NUM_CH-1:0] do_start;
    logic [NUM_CH-1:0] do_done;
    logic              finish_seen;
    logic              all_idle;
    logic [CNT_W-1:0]  sel_start;
    logic [CNT_W-1:0]  sel_done;
    logic [CNT_W-1:0]  sel_max;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // State register
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) state[i] <= IDLE;
            else       state[i] <= state_next[i];
        end
    end

    // Next state and count strobes
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_next[i] = state[i];
            do_start[i]   = 1'b0;
            do_done[i]    = 1'b0;
            case (state[i])
                IDLE: begin
                    if (ap_start[i] && ap_ready[i]) begin
                        do_start[i]   = 1'b1;
                        state_next[i] = BUSY;
                    end
                end
                BUSY: begin
                    // A start while busy is only accepted together with a
                    // completing done+continue (back-to-back transaction).
                    if (ap_done[i]) begin
                        do_done[i] = 1'b1;
                        if (!ap_continue[i]) begin
                            state_next[i] = WAIT_CONT;
                        end else if (ap_start[i] && ap_ready[i]) begin
                            do_start[i]   = 1'b1;
                            state_next[i] = BUSY;
                        end else begin
                            state_next[i] = IDLE;
                        end
                    end
                end
                WAIT_CONT: begin
                    if (ap_continue[i]) state_next[i] = IDLE;
                end
                default: state_next[i] = IDLE;
            endcase
            if (mon_complete) begin
                state_next[i] = state[i];
                do_start[i]   = 1'b0;
                do_done[i]    = 1'b0;
            end
        end
    end

    // Statistics. Latency includes both the start and the done cycle, so
    // lat_cur is loaded with 1 on start and max_lat takes lat_cur+1 on done.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                start_cnt[i] <= '0;
                done_cnt[i]  <= '0;
                max_lat[i]   <= '0;
                lat_cur[i]   <= '0;
            end else begin
                if (do_start[i]) start_cnt[i] <= sat_inc(start_cnt[i]);
                if (do_done[i]) begin
                    done_cnt[i] <= sat_inc(done_cnt[i]);
                    if (sat_inc(lat_cur[i]) > max_lat[i]) max_lat[i] <= sat_inc(lat_cur[i]);
                end
                if (do_start[i])
                    lat_cur[i] <= CNT_W'(1);
                else if (state[i] == BUSY && !mon_complete)
                    lat_cur[i] <= sat_inc(lat_cur[i]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_busy[i] = (state[i] != IDLE);
    end

    assign all_idle = (ch_busy == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            finish_seen  <= 1'b0;
            mon_complete <= 1'b0;
        end else begin
            if (finish) finish_seen <= 1'b1;
            if (finish_seen && all_idle) mon_complete <= 1'b1;
        end
    end

    // Readout mux; unmatched rd_sel values fall through to zero.
    always_comb begin
        sel_start = '0;
        sel_done  = '0;
        sel_max   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == 4'(i)) begin
                sel_start = start_cnt[i];
                sel_done  = done_cnt[i];
                sel_max   = max_lat[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_start_cnt <= '0;
            rd_done_cnt  <= '0;
            rd_max_lat   <= '0;
        end else begin
            rd_start_cnt <= sel_start;
            rd_done_cnt  <= sel_done;
            rd_max_lat   <= sel_max;
        end
    end

`ifdef DF_MON_STALL_DETECT_EN
    localparam int RUN_W = $clog2(STALL_LIMIT + 1);

    logic [RUN_W-1:0] run_cnt [NUM_CH];

    // Run counter saturates at the limit; the flag is sticky until reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                run_cnt[i] <= '0;
                stall[i]   <= 1'b0;
            end else if (!mon_complete) begin
                if (state[i] == IDLE)
                    run_cnt[i] <= '0;
                else if (run_cnt[i] != RUN_W'(STALL_LIMIT))
                    run_cnt[i] <= run_cnt[i] + RUN_W'(1);
                if (run_cnt[i] == RUN_W'(STALL_LIMIT)) stall[i] <= 1'b1;
            end
        end
    end
`else
    assign stall = '0;
`endif

endmodule

// File: tb/tb_df_channel_monitor.sv
module tb_df_channel_monitor;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
`ifdef DF_MON_STALL_DETECT_EN
    localparam bit SD = 1'b1;
`else
    localparam bit SD = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              finish;
    logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
    logic [3:0]        rd_sel;
    logic [CNT_W-1:0]  rd_start_cnt, rd_done_cnt, rd_max_lat;
    logic [NUM_CH-1:0] ch_busy, stall;
    logic              mon_complete;

    df_channel_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STALL_LIMIT(16)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .rd_sel(rd_sel),
        .rd_start_cnt(rd_start_cnt), .rd_done_cnt(rd_done_cnt), .rd_max_lat(rd_max_lat),
        .ch_busy(ch_busy), .stall(stall), .mon_complete(mon_complete)
    );

    always #5 clock = ~clock;

    typedef struct {
        string            name;
        logic [CNT_W-1:0] s, d, m;
        logic [1:0]       busy, stl;
        logic             mc;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expected record is presented per check strobe.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            @(negedge clock);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: strobe with empty queue");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (rd_start_cnt !== e.s || rd_done_cnt !== e.d || rd_max_lat !== e.m ||
                    ch_busy !== e.busy || stall !== e.stl || mon_complete !== e.mc) begin
                    errors++;
                    $display("FAIL %s: got start=%0d done=%0d maxlat=%0d busy=%b stall=%b complete=%b, expected start=%0d done=%0d maxlat=%0d busy=%b stall=%b complete=%b",
                             e.name, rd_start_cnt, rd_done_cnt, rd_max_lat, ch_busy, stall, mon_complete,
                             e.s, e.d, e.m, e.busy, e.stl, e.mc);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic hs(input logic [1:0] st, input logic [1:0] rd, input logic [1:0] dn, input logic [1:0] ct);
        ap_start = st; ap_ready = rd; ap_done = dn; ap_continue = ct;
    endtask

    // Called at a negedge; consumes one rising edge, returns at the next negedge.
    task automatic check(input string nm, input logic [3:0] sel,
                         input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] m,
                         input logic [1:0] b, input logic [1:0] st, input logic mc);
        exp_t e;
        rd_sel = sel;
        e.name = nm; e.s = s; e.d = d; e.m = m; e.busy = b; e.stl = st; e.mc = mc;
        exp_q.push_back(e);
        @(posedge clock);
        -> chk_ev;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; finish = 1'b0; rd_sel = 4'd0;
        hs(2'b00, 2'b00, 2'b00, 2'b00);
        cyc(3);
        reset = 1'b0;
        check("reset_state", 4'd0, 0, 0, 0, 2'b00, 2'b00, 1'b0);

        // ch0 single transaction: 6-cycle latency
        hs(2'b01, 2'b01, 2'b00, 2'b00); cyc(1);
        hs(2'b00, 2'b00, 2'b00, 2'b00);
        check("ch0_busy", 4'd0, 1, 0, 0, 2'b01, 2'b00, 1'b0);
        cyc(3);
        hs(2'b00, 2'b00, 2'b01, 2'b01); cyc(1);
        hs(2'b00, 2'b00, 2'b00, 2'b00);
        check("ch0_single", 4'd0, 1, 1, 6, 2'b00, 2'b00, 1'b0);

        // ch1 done held with continue low
        hs(2'b10, 2'b10, 2'b00, 2'b00); cyc(1);
        hs(2'b00, 2'b00, 2'b00, 2'b00); cyc(1);
        hs(2'b00, 2'b00, 2'b10, 2'b00); cyc(1);
        check("ch1_wait_cont", 4'd1, 1, 1, 3, 2'b10, 2'b00, 1'b0);
        cyc(1);
        hs(2'b00, 2'b00, 2'b00, 2'b10);
        check("ch1_continue", 4'd1, 1, 1, 3, 2'b00, 2'b00, 1'b0);
        hs(2'b00, 2'b00, 2'b00, 2'b00);

        // ch1 long transaction: stall detection
        hs(2'b10, 2'b10, 2'b00, 2'b00); cyc(1);
        hs(2'b00, 2'b00, 2'b00, 2'b00); cyc(9);
        check("ch1_busy10", 4'd1, 2, 1, 3, 2'b10, 2'b00, 1'b0);
        cyc(9);
        check("ch1_busy20", 4'd1, 2, 1, 3, 2'b10, SD ? 2'b10 : 2'b00, 1'b0);
        hs(2'b00, 2'b00, 2'b10, 2'b10); cyc(1);
        hs(2'b00, 2'b00, 2'b00, 2'b00);
        check("ch1_stall_sticky", 4'd1, 2, 2, 22, 2'b00, SD ? 2'b10 : 2'b00, 1'b0);

        // ch0 back-to-back x300: saturation
        hs(2'b01, 2'b01, 2'b00, 2'b00); cyc(1);
        hs(2'b01, 2'b01, 2'b01, 2'b01); cyc(300);
        hs(2'b00, 2'b00, 2'b01, 2'b01); cyc(1);
        hs(2'b00, 2'b00, 2'b00, 2'b00);
        check("ch0_saturate", 4'd0, 255, 255, 6, 2'b00, SD ? 2'b11 : 2'b00, 1'b0);
        check("sel_out_of_range", 4'd2, 0, 0, 0, 2'b00, SD ? 2'b11 : 2'b00, 1'b0);

        // reset mid-transaction
        hs(2'b01, 2'b01, 2'b00, 2'b00); cyc(1);
        hs(2'b00, 2'b00, 2'b00, 2'b00); cyc(2);
        reset = 1'b1; cyc(1); reset = 1'b0;
        check("reset_mid_sel0", 4'd0, 0, 0, 0, 2'b00, 2'b00, 1'b0);
        check("reset_mid_sel5", 4'd5, 0, 0, 0, 2'b00, 2'b00, 1'b0);

        // finish while ch0 busy
        hs(2'b01, 2'b01, 2'b00, 2'b00); cyc(1);
        hs(2'b00, 2'b00, 2'b00, 2'b00);
        finish = 1'b1; cyc(1); finish = 1'b0;
        cyc(2);
        check("finish_busy", 4'd0, 1, 0, 0, 2'b01, 2'b00, 1'b0);
        hs(2'b00, 2'b00, 2'b01, 2'b01);
        check("finish_done_edge", 4'd0, 1, 0, 0, 2'b00, 2'b00, 1'b0);
        hs(2'b00, 2'b00, 2'b00, 2'b00);
        check("complete_rise", 4'd0, 1, 1, 6, 2'b00, 2'b00, 1'b1);
        hs(2'b01, 2'b01, 2'b00, 2'b00); cyc(3);
        hs(2'b00, 2'b00, 2'b00, 2'b00);
        check("frozen", 4'd0, 1, 1, 6, 2'b00, 2'b00, 1'b1);

        cyc(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
